vector_loader: RTL and testbench

- Write-side controller for the team's registered, parallel-read vector memory (WIDTH×SIZE array, single write port, whole array presented on data_out one cycle after each edge).
- Accepts a stream of WIDTH-bit words over a valid/ready handshake and writes SIZE consecutive words to addresses 0..SIZE-1.
- Raises frame_valid once the memory's parallel output reflects the complete frame, and holds the frame stable until the downstream MAC/consumer releases it.

---
 rtl/vector_loader.sv | 125 ++++++++++++
 tb/tb_vector_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_loader.sv
// rtl/vector_loader.sv - write-side frame loader for the parallel-read vector memory (optional abort: VECTOR_LOADER_ABORT_EN)
module vector_loader #(
  parameter int WIDTH   = 16,
  parameter int SIZE    = 64,
  parameter int LOGSIZE = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [WIDTH-1:0]   mem_data_in,
  output logic [LOGSIZE-1:0] mem_addr,
  output logic               mem_wr_en,
  output logic               frame_valid,
  input  logic               frame_release,
  output logic [7:0]         frame_count
`ifdef VECTOR_LOADER_ABORT_EN
  ,
  input  logic               abort
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    FULL   = 2'd3
  } state_t;

  // Explicit last-address compare so SIZE need not be a power of two.
  localparam logic [LOGSIZE-1:0] LAST_ADDR = LOGSIZE'(SIZE - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [LOGSIZE-1:0] r_wr_ptr;
  logic [LOGSIZE-1:0] w_next_ptr;
  logic               r_s_ready;
  logic               r_frame_valid;
  logic [7:0]         r_frame_count;
  logic               w_accept;
  logic               w_last;
  logic               w_abort;
  logic               w_count_inc;

`ifdef VECTOR_LOADER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept    = s_valid & r_s_ready;
  assign w_last      = (r_wr_ptr == LAST_ADDR);
  assign w_count_inc = (r_state == SETTLE) & ~w_abort;

  // Memory write port is driven straight from the handshake in the accepting cycle.
  assign s_ready     = r_s_ready;
  assign mem_wr_en   = w_accept;
  assign mem_addr    = r_wr_ptr;
  assign mem_data_in = s_data;
  assign frame_valid = r_frame_valid;
  assign frame_count = r_frame_count;

  // Next-state and next write pointer; abort wins over frame completion.
  always_comb begin
    w_next_state = r_state;
    w_next_ptr   = r_wr_ptr;
    case (r_state)
      IDLE: begin
        w_next_state = LOAD;
      end
      LOAD: begin
        if (w_abort) begin
          w_next_ptr = '0;
        end else if (w_accept) begin
          if (w_last) begin
            w_next_ptr   = '0;
            w_next_state = SETTLE;
          end else begin
            w_next_ptr = r_wr_ptr + LOGSIZE'(1);
          end
        end
      end
      SETTLE: begin
        // One cycle for the memory's output register to catch the last word.
        w_next_ptr   = '0;
        w_next_state = w_abort ? LOAD : FULL;
      end
      FULL: begin
        if (frame_release | w_abort) begin
          w_next_state = LOAD;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_ptr   = '0;
      end
    endcase
  end

  // State, pointer and registered decodes of the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_wr_ptr      <= '0;
      r_s_ready     <= 1'b0;
      r_frame_valid <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_wr_ptr      <= w_next_ptr;
      r_s_ready     <= (w_next_state == LOAD);
      r_frame_valid <= (w_next_state == FULL);
    end
  end

  // Completed-frame counter, wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_count <= 8'd0;
    end else if (w_count_inc) begin
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_vector_loader.sv
// tb/tb_vector_loader.sv - self-checking bench for vector_loader with a behavioural memory and frame model
module tb_vector_loader;

  localparam int W  = 16;
  localparam int SZ = 4;
  localparam int LS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  mem_data_in;
  logic [LS-1:0] mem_addr;
  logic          mem_wr_en;
  logic          frame_valid;
  logic          frame_release;
  logic [7:0]    frame_count;
  logic          abort_in = 1'b0;

  always #5 clk = ~clk;

  vector_loader #(.WIDTH(W), .SIZE(SZ), .LOGSIZE(LS)) dut (
    .clk(clk),
    .reset(reset),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .mem_data_in(mem_data_in),
    .mem_addr(mem_addr),
    .mem_wr_en(mem_wr_en),
    .frame_valid(frame_valid),
    .frame_release(frame_release),
    .frame_count(frame_count)
`ifdef VECTOR_LOADER_ABORT_EN
    ,
    .abort(abort_in)
`endif
  );

  // External memory: single write port, whole array registered onto data_out each edge.
  logic [W-1:0]    mem [SZ];
  logic [W*SZ-1:0] data_out;
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_data_in;
    for (int i = 0; i < SZ; i++) data_out[i*W +: W] <= mem[i];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts words into a frame, then a settle cycle, then a held frame.
  bit              m_live;
  int              m_n;
  bit              m_settle;
  bit              m_full;
  int              m_count;
  logic [W-1:0]    m_pend [SZ];
  logic [W*SZ-1:0] m_frame;
  int              wr_log[$];
  int              fv_cycles;

  task automatic model_reset();
    m_live = 0; m_n = 0; m_settle = 0; m_full = 0; m_count = 0;
  endtask

  task automatic model_update();
    if (!m_live) begin
      m_live = 1;
    end else if (m_full) begin
      if (frame_release || abort_in) m_full = 0;
    end else if (m_settle) begin
      m_settle = 0;
      if (abort_in) begin
        m_n = 0;
      end else begin
        m_full  = 1;
        m_count = (m_count + 1) % 256;
        for (int i = 0; i < SZ; i++) m_frame[i*W +: W] = m_pend[i];
      end
    end else begin
      if (s_valid) m_pend[m_n] = s_data;
      if (abort_in) m_n = 0;
      else if (s_valid) begin
        if (m_n == SZ - 1) begin
          m_n = 0;
          m_settle = 1;
        end else begin
          m_n++;
        end
      end
    end
  endtask

  task automatic model_check();
    bit rdy;
    rdy = m_live && !m_settle && !m_full;
    chk("s_ready", s_ready, rdy);
    chk("mem_wr_en", mem_wr_en, rdy && s_valid);
    chk("mem_addr", mem_addr, m_n);
    chk("frame_valid", frame_valid, m_full);
    chk("frame_count", frame_count, m_count);
    if (rdy && s_valid) chk("mem_data_in", mem_data_in, s_data);
    if (m_full) chk("data_out", data_out, m_frame);
  endtask

  // One clock cycle with the current inputs: check, then advance model at the edge.
  task automatic cyc();
    #1;
    if (!reset) model_reset();
    model_check();
    if (mem_wr_en) wr_log.push_back(int'(mem_addr));
    if (frame_valid) fv_cycles++;
    @(posedge clk);
    if (!reset) model_reset();
    else model_update();
    #1;
  endtask

  typedef struct {
    logic          v;
    logic [W-1:0]  d;
    logic          rel;
    logic          rdy;
    logic          we;
    logic [LS-1:0] addr;
    logic          fv;
    logic [7:0]    cnt;
  } vec_t;

  vec_t tbl [7];

  logic [W*SZ-1:0] snap;
  logic [W*SZ-1:0] exp_frame;
  int              rises;
  bit              prev_fv;
  int              budget;

  initial begin
    tbl[0] = '{1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0};
    tbl[1] = '{1'b1, 16'h0011, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'd0};
    tbl[2] = '{1'b1, 16'h0022, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 8'd0};
    tbl[3] = '{1'b1, 16'h0033, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 8'd0};
    tbl[4] = '{1'b1, 16'h0044, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 8'd0};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 8'd1};
    exp_frame = {16'h0044, 16'h0033, 16'h0022, 16'h0011};

    reset = 1'b0; s_valid = 1'b0; s_data = '0; frame_release = 1'b0;
    model_reset();
    repeat (3) cyc();
    reset = 1'b1;

    // Table-driven first frame, continuous valid.
    for (int i = 0; i < 7; i++) begin
      s_valid = tbl[i].v; s_data = tbl[i].d; frame_release = tbl[i].rel;
      #1;
      chk("tbl_ready", s_ready, tbl[i].rdy);
      chk("tbl_wr_en", mem_wr_en, tbl[i].we);
      chk("tbl_addr", mem_addr, tbl[i].addr);
      chk("tbl_fv", frame_valid, tbl[i].fv);
      chk("tbl_count", frame_count, tbl[i].cnt);
      if (tbl[i].we) chk("tbl_data_in", mem_data_in, tbl[i].d);
      if (i == 6) chk("tbl_data_out", data_out, exp_frame);
      cyc();
    end

    // FULL with valid held: nothing written, frame stable.
    s_valid = 1'b1; s_data = 16'hAAAA;
    snap = data_out;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("full_hold_wr_en", mem_wr_en, 1'b0);
      chk("full_hold_stable", data_out, snap);
      cyc();
    end

    // Release pulse, then a frame with a 3-cycle gap after word 1.
    frame_release = 1'b1;
    cyc();
    frame_release = 1'b0;
    s_data = 16'h0011;
    #1;
    chk("rel_fv_low", frame_valid, 1'b0);
    chk("rel_first_we", mem_wr_en, 1'b1);
    chk("rel_first_addr", mem_addr, 0);
    wr_log.delete();
    cyc();
    s_valid = 1'b0;
    repeat (3) cyc();
    s_valid = 1'b1;
    s_data = 16'h0022; cyc();
    s_data = 16'h0033; cyc();
    s_data = 16'h0044; cyc();
    s_valid = 1'b0;
    cyc();
    #1;
    chk("gap_writes", wr_log.size(), 4);
    for (int i = 0; i < wr_log.size() && i < 4; i++) chk("gap_addr", wr_log[i], i);
    chk("gap_fv", frame_valid, 1'b1);
    chk("gap_count", frame_count, 8'd2);
    chk("gap_data_out", data_out, exp_frame);

    // Reset after two words of the next frame.
    frame_release = 1'b1;
    cyc();
    frame_release = 1'b0;
    s_valid = 1'b1;
    s_data = 16'h0055; cyc();
    s_data = 16'h0066; cyc();
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_ready", s_ready, 1'b0);
    chk("rst_wr_en", mem_wr_en, 1'b0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_fv", frame_valid, 1'b0);
    chk("rst_count", frame_count, 8'd0);
    cyc();
    reset = 1'b1;
    s_data = 16'h0077;
    cyc();
    wr_log.delete();
    cyc();
    chk("rst_restart_writes", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("rst_restart_addr", wr_log[0], 0);
    chk("rst_restart_count", frame_count, 8'd0);
    s_valid = 1'b0;

    // 256 frames with release held high.
    reset = 1'b0; cyc(); reset = 1'b1;
    frame_release = 1'b1; s_valid = 1'b1;
    rises = 0; prev_fv = 0; fv_cycles = 0; budget = 0;
    while (rises < 256 && budget < 4000) begin
      s_data = W'($urandom);
      cyc();
      budget++;
      if (frame_valid && !prev_fv) rises++;
      prev_fv = frame_valid;
    end
    chk("wrap_rises", rises, 256);
    chk("wrap_count", frame_count, 8'd0);
    chk("wrap_once_per_full", fv_cycles, 255);
    frame_release = 1'b0; s_valid = 1'b0;

`ifdef VECTOR_LOADER_ABORT_EN
    // Abort after word 3 of 4.
    reset = 1'b0; cyc(); reset = 1'b1;
    cyc();
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin s_data = W'(16'h0100 + i); cyc(); end
    s_valid = 1'b0; abort_in = 1'b1;
    cyc();
    abort_in = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = W'(16'h0200 + i);
      #1;
      chk("abort_addr", mem_addr, i);
      chk("abort_fv_low", frame_valid, 1'b0);
      cyc();
    end
    s_valid = 1'b0;
    #1; chk("abort_settle_fv", frame_valid, 1'b0);
    cyc();
    #1; chk("abort_full_fv", frame_valid, 1'b1);
    chk("abort_count", frame_count, 8'd1);
    frame_release = 1'b1; cyc(); frame_release = 1'b0;
`endif

    // Randomized traffic against the model.
    reset = 1'b0; cyc(); reset = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      s_valid = ($urandom % 10) < 7;
      s_data = W'($urandom);
      frame_release = ($urandom % 4) == 0;
`ifdef VECTOR_LOADER_ABORT_EN
      abort_in = ($urandom % 40) == 0;
`endif
      if (($urandom % 500) == 0) reset = 1'b0;
      cyc();
      reset = 1'b1;
    end
    abort_in = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
